// File: rtl/serial_frame_capture.sv
// -----------------------------------------------------------------------------
// serial_frame_capture
//   Sits behind the 12-bit sync-word detector (1110_1101_1011). When the
//   detector's hit pulse arrives, the following PAYLOAD_W serial bits are
//   deserialized MSB-first and handed out on a valid/ready register. A frame
//   that completes while the output slot is still occupied is dropped, and
//   sticky overflow_o is raised.
//
//   Optional build macro PARITY_CHK_EN: each frame carries one trailing
//   even-parity bit. A frame that fails the check is discarded silently
//   (no load, no overflow) and parity_err_o pulses for one cycle.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   x_i          serial bit stream (the same stream the detector sees)
//   det_i        detector hit; x_i already carries payload MSB in this cycle
//   ready_i      downstream accepts payload_o when valid_o && ready_i
//   ovf_clr_i    synchronous clear of overflow_o (a drop in the same cycle wins)
//   payload_o    captured word, first-received bit in the MSB
//   valid_o      payload_o holds an unconsumed frame
//   busy_o       high while capturing
//   overflow_o   sticky: a completed frame was dropped
//   parity_err_o (PARITY_CHK_EN only) one-cycle pulse on a parity failure
// -----------------------------------------------------------------------------
module serial_frame_capture #(
   parameter int PAYLOAD_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 x_i,
   input  logic                 det_i,
   input  logic                 ready_i,
   input  logic                 ovf_clr_i,
   output logic [PAYLOAD_W-1:0] payload_o,
   output logic                 valid_o,
   output logic                 busy_o,
`ifdef PARITY_CHK_EN
   output logic                 parity_err_o,
`endif
   output logic                 overflow_o
);

`ifdef PARITY_CHK_EN
   localparam int CAP_LEN = PAYLOAD_W + 1;
`else
   localparam int CAP_LEN = PAYLOAD_W;
`endif
   localparam int CW = $clog2(PAYLOAD_W + 1);

   typedef enum logic {HUNT, CAPTURE} state_t;

   state_t                state, next_state;
   logic [CW-1:0]         cnt;
   logic [PAYLOAD_W-1:0]  sh;
   logic [PAYLOAD_W-1:0]  shifted;
   logic [PAYLOAD_W-1:0]  word;
   logic                  done;
   logic                  good;
   logic                  free;

   assign shifted = {sh[PAYLOAD_W-2:0], x_i};
   // Slot can take a new word if empty or being drained this very cycle.
   assign free    = !valid_o || ready_i;
   assign busy_o  = (state == CAPTURE);

`ifdef PARITY_CHK_EN
   // On the parity bit the shift register already holds the whole payload.
   assign word = sh;
   assign good = ~(^sh ^ x_i);
`else
   assign word = shifted;
   assign good = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= HUNT;
      else       state <= next_state;
   end

   // det_i is deliberately ignored outside HUNT: payload bits may look like
   // a sync word, and there is no mid-frame re-sync.
   always_comb begin
      next_state = state;
      done       = 1'b0;
      case (state)
         HUNT:    if (det_i) next_state = CAPTURE;
         CAPTURE: if (cnt == CW'(CAP_LEN - 1)) begin
                     done       = 1'b1;
                     next_state = HUNT;
                  end
         default: next_state = HUNT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         sh  <= '0;
      end else if (state == HUNT) begin
         if (det_i) begin
            sh  <= shifted;
            cnt <= CW'(1);
         end
      end else begin
         sh  <= shifted;
         cnt <= done ? '0 : cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         payload_o  <= '0;
         valid_o    <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         if (valid_o && ready_i) valid_o <= 1'b0;
         if (done && good && free) begin
            payload_o <= word;
            valid_o   <= 1'b1;
         end
         if (done && good && !free) overflow_o <= 1'b1;
         else if (ovf_clr_i)        overflow_o <= 1'b0;
      end
   end

`ifdef PARITY_CHK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) parity_err_o <= 1'b0;
      else       parity_err_o <= done && !good;
   end
`endif

endmodule
